// File: rtl/buzzer_sfx_arbiter.sv
// Buzzer owner arbiter: passes music_beep through when idle, plays prioritised 4-note SFX otherwise.
// Optional MUSIC_PAUSE_EN adds a music_pause output mirroring sfx_busy.
module buzzer_sfx_arbiter #(
    parameter int unsigned NOTE_TICKS   = 2_500_000,
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       music_beep,
    input  logic [3:0] sfx_req,
    output logic       beep,
    output logic       sfx_busy,
    output logic [1:0] active_id
`ifdef MUSIC_PAUSE_EN
    ,
    output logic       music_pause
`endif
);

    localparam int unsigned DCW = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [DCW-1:0] DC_LAST = DCW'(NOTE_TICKS - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t         state_q, state_d;
    logic [1:0]     id_q, id_d;
    logic [1:0]     ni_q, ni_d;
    logic [16:0]    tc_q, tc_d;
    logic [DCW-1:0] dc_q, dc_d;
    logic           beep_q, beep_d;

    logic           req_any;
    logic [1:0]     req_id;
    logic [16:0]    period;

    function automatic logic [16:0] sfx_period(input logic [1:0] id, input logic [1:0] ni);
        logic [16:0] p;
        case ({id, ni})
            4'b00_00: p = 17'd50607;
            4'b00_01: p = 17'd63775;
            4'b01_00: p = 17'd95602;
            4'b01_01: p = 17'd127551;
            4'b01_10: p = 17'd95602;
            4'b01_11: p = 17'd127551;
            4'b10_00: p = 17'd75872;
            4'b10_01: p = 17'd63775;
            4'b10_10: p = 17'd56818;
            4'b10_11: p = 17'd50607;
            4'b11_00: p = 17'd127551;
            4'b11_01: p = 17'd127551;
            4'b11_10: p = 17'd127551;
            4'b11_11: p = 17'd127551;
            default:  p = '0;
        endcase
        return p >> PERIOD_SHIFT;
    endfunction

    assign req_any = |sfx_req;
    always_comb begin
        if (sfx_req[3])      req_id = 2'd3;
        else if (sfx_req[2]) req_id = 2'd2;
        else if (sfx_req[1]) req_id = 2'd1;
        else                 req_id = 2'd0;
    end

    assign period = sfx_period(id_q, ni_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ni_d    = ni_q;
        tc_d    = tc_q;
        dc_d    = dc_q;
        beep_d  = beep_q;
        case (state_q)
            IDLE: begin
                beep_d = music_beep;
                if (req_any) begin
                    state_d = PLAY;
                    id_d    = req_id;
                    ni_d    = '0;
                    tc_d    = '0;
                    dc_d    = '0;
                    beep_d  = 1'b0;
                end
            end
            PLAY: begin
                beep_d = (period != '0) && (tc_q >= (period >> 1));
                if (period == '0 || tc_q == period - 17'd1) tc_d = '0;
                else                                        tc_d = tc_q + 17'd1;
                if (dc_q == DC_LAST) begin
                    dc_d = '0;
                    ni_d = ni_q + 2'd1;
                    tc_d = '0;
                    if (ni_q == 2'd3) state_d = IDLE;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
                // A qualifying request overrides everything above, including the final-note exit.
                if (req_any && req_id >= id_q) begin
                    state_d = PLAY;
                    id_d    = req_id;
                    ni_d    = '0;
                    tc_d    = '0;
                    dc_d    = '0;
                    beep_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            ni_q    <= '0;
            tc_q    <= '0;
            dc_q    <= '0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ni_q    <= ni_d;
            tc_q    <= tc_d;
            dc_q    <= dc_d;
            beep_q  <= beep_d;
        end
    end

    assign beep      = beep_q;
    assign sfx_busy  = (state_q == PLAY);
    assign active_id = id_q;
`ifdef MUSIC_PAUSE_EN
    assign music_pause = (state_q == PLAY);
`endif

endmodule
